ifetch_ir: RTL and testbench

- Instruction fetch and instruction-register stage directly upstream of the microprogrammed control unit.
- Holds the PC and performs one instruction fetch per request over a req/gnt/rvalid memory handshake.
- Latches the fetched word into the IR and presents the decoded fields (opcode, r, rs1, rs2, imm sources) to the control unit and datapath.
- Fetches are started by the control unit's fetch micro-op, which waits on fetch_done.

---
 rtl/ifetch_ir.sv | 112 +++++++++++
 tb/tb_ifetch_ir.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ir.sv
// Instruction fetch and IR stage: one fetch per request over a req/gnt/rvalid
// handshake, with pc redirect handling and decoded IR fields.
module ifetch_ir #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_start,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic [6:0]      opcode,
  output logic [14:0]     r,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            busy,
  output logic            fetch_done,
  output logic            misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] target_aligned;
  logic            complete;

  // Misaligned targets are still loaded, with the low bits dropped.
  assign target_aligned = {pc_target[XLEN-1:2], 2'b00};

  assign complete = ((state == REQ) && imem_gnt && imem_rvalid) ||
                    ((state == WAIT) && imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= NOP_INSTR;
      imem_req   <= 1'b0;
      fetch_done <= 1'b0;
      misalign   <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
    end else begin
      fetch_done <= 1'b0;
      if (pc_load && (pc_target[1:0] != 2'b00))
        misalign <= 1'b1;

      case (state)
        IDLE: begin
          if (pc_load)
            pc <= target_aligned;
          if (fetch_start) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (complete) begin
            ir         <= imem_rdata;
            fetch_done <= 1'b1;
            imem_req   <= 1'b0;
            state      <= IDLE;
            pend_valid <= 1'b0;
            // A redirect in the completion cycle beats an older pending one.
            if (pc_load)
              pc <= target_aligned;
            else if (pend_valid)
              pc <= pend_pc;
            else
              pc <= pc + XLEN'(4);
          end else begin
            if (pc_load) begin
              pend_valid <= 1'b1;
              pend_pc    <= target_aligned;
            end
            if ((state == REQ) && imem_gnt) begin
              state    <= WAIT;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // pc never moves while a fetch is in flight, so it doubles as the address.
  assign imem_addr = pc;
  assign busy      = (state != IDLE);
  assign opcode    = ir[6:0];
  assign r         = {ir[31:25], ir[14:12], ir[11:7]};
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_ifetch_ir;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, ir;
  logic [6:0]  opcode;
  logic [14:0] r;
  logic [4:0]  rs1, rs2;
  logic        busy, fetch_done, misalign;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  ifetch_ir dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .opcode(opcode), .r(r), .rs1(rs1), .rs2(rs2),
    .busy(busy), .fetch_done(fetch_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a fetch is "in flight" until its data arrives;
  // redirects seen during a fetch queue up and the newest one wins.
  logic [31:0] m_pc, m_ir;
  bit          m_inflight, m_granted, m_done, m_mis;
  logic [31:0] pend_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RESET_PC; m_ir = NOP_INSTR; m_inflight = 0; m_granted = 0;
      m_done = 0; m_mis = 0; pend_q.delete();
    end else begin
      m_done = 0;
      if (pc_load && pc_target[1:0] != 2'b00) m_mis = 1;
      if (!m_inflight) begin
        if (pc_load) m_pc = pc_target & 32'hFFFF_FFFC;
        if (fetch_start) begin m_inflight = 1; m_granted = 0; end
      end else begin
        bit got_data;
        if (pc_load) pend_q.push_back(pc_target & 32'hFFFF_FFFC);
        got_data = imem_rvalid && (m_granted || imem_gnt);
        if (imem_gnt) m_granted = 1;
        if (got_data) begin
          m_ir = imem_rdata;
          m_done = 1;
          m_pc = (pend_q.size() > 0) ? pend_q[$] : m_pc + 32'd4;
          pend_q.delete();
          m_inflight = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_pc", pc, m_pc);
      chk("m_ir", ir, m_ir);
      chk("m_opcode", {25'd0, opcode}, {25'd0, m_ir[6:0]});
      chk("m_r", {17'd0, r}, {17'd0, m_ir[31:25], m_ir[14:12], m_ir[11:7]});
      chk("m_rs1", {27'd0, rs1}, {27'd0, m_ir[19:15]});
      chk("m_rs2", {27'd0, rs2}, {27'd0, m_ir[24:20]});
      chk("m_busy", {31'd0, busy}, {31'd0, m_inflight});
      chk("m_req", {31'd0, imem_req}, {31'd0, m_inflight && !m_granted});
      if (imem_req) chk("m_addr", imem_addr, m_pc);
      chk("m_done", {31'd0, fetch_done}, {31'd0, m_done});
      chk("m_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 0; pc_load = 0; imem_gnt = 0; imem_rvalid = 0;
  endtask

  int done_cnt;

  initial begin
    step(); step();
    rst_n = 1; started = 1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", ir, NOP_INSTR);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    step();

    // Minimum-latency fetch
    fetch_start = 1; step();
    idle_inputs();
    chk("s1_req", {31'd0, imem_req}, 32'd1);
    chk("s1_addr", imem_addr, 32'd0);
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0062_8293; step();
    idle_inputs();
    chk("s1_done", {31'd0, fetch_done}, 32'd1);
    chk("s1_opcode", {25'd0, opcode}, 32'h13);
    chk("s1_r", {17'd0, r}, {17'd0, 7'h00, 3'h0, 5'h05});
    chk("s1_rs1", {27'd0, rs1}, 32'd5);
    chk("s1_rs2", {27'd0, rs2}, 32'd6);
    chk("s1_pc", pc, 32'd4);
    step();
    chk("s1_done_once", {31'd0, fetch_done}, 32'd0);

    // Delayed grant and data; stray fetch_start while busy is ignored
    done_cnt = 0;
    fetch_start = 1; step(); fetch_start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("s2_req_held", {31'd0, imem_req}, 32'd1);
      chk("s2_addr", imem_addr, 32'd4);
      step();
    end
    chk("s2_req_held", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1; step(); imem_gnt = 0;
    chk("s2_req_drop", {31'd0, imem_req}, 32'd0);
    fetch_start = 1; step(); fetch_start = 0;
    chk("s2_pc_hold", pc, 32'd4);
    imem_rvalid = 1; imem_rdata = 32'h00A0_0513; step(); imem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      if (fetch_done) done_cnt++;
      step();
    end
    chk("s2_done_pulses", done_cnt, 32'd1);
    chk("s2_pc", pc, 32'd8);
    chk("s2_ir", ir, 32'h00A0_0513);
    chk("s2_busy", {31'd0, busy}, 32'd0);

    // Redirect during WAIT
    fetch_start = 1; step(); fetch_start = 0;
    chk("s3_addr", imem_addr, 32'd8);
    imem_gnt = 1; step(); imem_gnt = 0;
    pc_load = 1; pc_target = 32'h100; step(); pc_load = 0;
    chk("s3_pc_hold", pc, 32'd8);
    imem_rvalid = 1; imem_rdata = 32'h0000_006F; step(); imem_rvalid = 0;
    chk("s3_pc", pc, 32'h100);
    chk("s3_ir", ir, 32'h0000_006F);
    step();

    // Misaligned load in IDLE, sticky across a fetch
    pc_load = 1; pc_target = 32'h102; step(); pc_load = 0;
    chk("s4_pc", pc, 32'h100);
    chk("s4_mis", {31'd0, misalign}, 32'd1);
    fetch_start = 1; step(); fetch_start = 0;
    chk("s4_addr", imem_addr, 32'h100);
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0010_0093; step();
    idle_inputs();
    chk("s4_pc_after", pc, 32'h104);
    chk("s4_mis_sticky", {31'd0, misalign}, 32'd1);

    // Load and start in the same cycle, then wrap
    pc_load = 1; pc_target = 32'hFFFF_FFFC; fetch_start = 1; step();
    idle_inputs();
    chk("s5_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0000_0013; step();
    idle_inputs();
    chk("s5_wrap", pc, 32'd0);

    // Reset mid-fetch, then a stray rvalid
    pc_load = 1; pc_target = 32'h40; step(); pc_load = 0;
    fetch_start = 1; step(); fetch_start = 0;
    imem_gnt = 1; step(); imem_gnt = 0;
    rst_n = 0; #1;
    chk("s6_ir", ir, NOP_INSTR);
    chk("s6_pc", pc, RESET_PC);
    chk("s6_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 0;
    chk("s6_no_done", {31'd0, fetch_done}, 32'd0);
    chk("s6_ir_after", ir, NOP_INSTR);
    chk("s6_pc_after", pc, RESET_PC);
    chk("s6_idle", {31'd0, busy}, 32'd0);
    chk("s6_mis_clr", {31'd0, misalign}, 32'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
